// File: rtl/pcie_dll_rx_seq.sv
`default_nettype none
// ============================================================================
// Module   : pcie_dll_rx_seq
// Purpose  : PCIe DLL receive path: LCRC/sequence check, RX buffer, Ack/Nak.
//            Optional statistics counters when DLL_RX_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_dll_rx_seq #(
    parameter int TL_W       = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int ACK_LAT    = 64,
    parameter int SEQ_W      = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tlp_valid_i,
    input  logic [TL_W+47:0]              tlp_i,
    input  logic                          lcrc_ok_i,
    output logic                          tlp_ready_o,
    output logic                          tl_valid_o,
    output logic [TL_W-1:0]               tl_data_o,
    input  logic                          tl_ready_i,
    output logic                          dllp_valid_o,
    output logic                          dllp_nak_o,
    output logic [SEQ_W-1:0]              dllp_seq_o,
    input  logic                          dllp_ready_i,
`ifdef DLL_RX_STATS_EN
    output logic [15:0]                   stat_bad_crc_o,
    output logic [15:0]                   stat_dup_o,
    output logic [15:0]                   stat_nak_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   credits_o
);

    localparam int                c_AW     = $clog2(FIFO_DEPTH);
    localparam int                c_CW     = c_AW + 1;
    localparam int                c_TW     = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;
    localparam logic [c_CW-1:0]   c_DEPTH  = c_CW'(FIFO_DEPTH);
    localparam logic [c_TW-1:0]   c_LAT_M1 = c_TW'(ACK_LAT - 1);
    localparam logic [SEQ_W-1:0]  c_HALF   = {1'b1, {(SEQ_W-1){1'b0}}};
    localparam logic [SEQ_W-1:0]  c_ONE    = SEQ_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND_ACK = 2'd1,
        S_SEND_NAK = 2'd2
    } state_t;

    state_t             r_state;
    logic [SEQ_W-1:0]   r_next_seq;
    logic               r_nak_sched;
    logic               r_nak_pend;
    logic               r_ack_pending;
    logic               r_ack_force;
    logic [c_TW-1:0]    r_ack_timer;

    logic [TL_W-1:0]    r_mem [0:FIFO_DEPTH-1];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [c_CW-1:0]    w_count_nxt;

    logic [SEQ_W-1:0]   w_seq;
    logic [TL_W-1:0]    w_body;
    logic [SEQ_W-1:0]   w_diff;
    logic               w_accept;
    logic               w_good;
    logic               w_dup;
    logic               w_bad;
    logic               w_push;
    logic               w_pop;
    logic               w_nak_req;
    logic               w_ack_req;
    logic               w_ack_done;
    logic               w_nak_done;
    logic               w_unused;

    assign w_seq    = tlp_i[TL_W+32 +: SEQ_W];
    assign w_body   = tlp_i[32 +: TL_W];
    assign w_unused = ^{tlp_i[TL_W+47:TL_W+32+SEQ_W], tlp_i[31:0]};

    assign tlp_ready_o = (r_count != c_DEPTH);
    assign tl_valid_o  = (r_count != '0);
    assign tl_data_o   = tl_valid_o ? r_mem[r_rd_ptr] : '0;

    // Duplicates lie up to half the sequence space behind next_rcv_seq.
    assign w_accept  = tlp_valid_i & tlp_ready_o;
    assign w_diff    = r_next_seq - w_seq;
    assign w_good    = lcrc_ok_i && (w_seq == r_next_seq);
    assign w_dup     = lcrc_ok_i && (w_diff != '0) && (w_diff <= c_HALF);
    assign w_bad     = !w_good && !w_dup;
    assign w_push    = w_accept & w_good;
    assign w_pop     = tl_valid_o & tl_ready_i;
    assign w_nak_req = w_accept & w_bad & ~r_nak_sched;

    assign w_ack_req  = r_ack_force | (r_ack_pending & (r_ack_timer == c_LAT_M1));
    assign w_ack_done = (r_state == S_SEND_ACK) & dllp_ready_i;
    assign w_nak_done = (r_state == S_SEND_NAK) & dllp_ready_i;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_body;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            credits_o <= c_DEPTH;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count   <= w_count_nxt;
            credits_o <= c_DEPTH - w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_next_seq    <= '0;
            r_nak_sched   <= 1'b0;
            r_nak_pend    <= 1'b0;
            r_ack_pending <= 1'b0;
            r_ack_force   <= 1'b0;
            r_ack_timer   <= '0;
            dllp_valid_o  <= 1'b0;
            dllp_nak_o    <= 1'b0;
            dllp_seq_o    <= '0;
        end else begin
            if (w_push) begin
                r_next_seq  <= r_next_seq + c_ONE;
                r_nak_sched <= 1'b0;
            end
            if (w_nak_req) begin
                r_nak_sched <= 1'b1;
            end

            // A Nak carries the same AckNak_Seq_Num, so it also retires a coalesced Ack.
            if (w_ack_done || w_nak_done) begin
                r_ack_pending <= 1'b0;
                r_ack_force   <= 1'b0;
                r_ack_timer   <= '0;
            end else if (r_ack_pending && (r_ack_timer != c_LAT_M1)) begin
                r_ack_timer <= r_ack_timer + c_TW'(1);
            end
            if (w_push) begin
                r_ack_pending <= 1'b1;
            end
            if (w_accept && w_dup) begin
                r_ack_force <= 1'b1;
            end

            if (w_nak_done) begin
                r_nak_pend <= 1'b0;
            end
            if (w_nak_req) begin
                r_nak_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_nak_pend) begin
                        r_state      <= S_SEND_NAK;
                        dllp_valid_o <= 1'b1;
                        dllp_nak_o   <= 1'b1;
                        dllp_seq_o   <= r_next_seq - c_ONE;
                    end else if (w_ack_req) begin
                        r_state      <= S_SEND_ACK;
                        dllp_valid_o <= 1'b1;
                        dllp_nak_o   <= 1'b0;
                        dllp_seq_o   <= r_next_seq - c_ONE;
                    end
                end
                S_SEND_ACK, S_SEND_NAK: begin
                    if (dllp_ready_i) begin
                        r_state      <= S_IDLE;
                        dllp_valid_o <= 1'b0;
                        dllp_nak_o   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    dllp_valid_o <= 1'b0;
                    dllp_nak_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DLL_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bad_crc_o <= '0;
            stat_dup_o     <= '0;
            stat_nak_o     <= '0;
        end else begin
            if (w_accept && !lcrc_ok_i && (stat_bad_crc_o != 16'hFFFF)) begin
                stat_bad_crc_o <= stat_bad_crc_o + 16'd1;
            end
            if (w_accept && w_dup && (stat_dup_o != 16'hFFFF)) begin
                stat_dup_o <= stat_dup_o + 16'd1;
            end
            if (w_nak_done && (stat_nak_o != 16'hFFFF)) begin
                stat_nak_o <= stat_nak_o + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_dll_rx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_dll_rx_seq
// Purpose  : Self-checking bench for pcie_dll_rx_seq with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_dll_rx_seq;

    localparam int c_TL_W    = 64;
    localparam int c_DEPTH   = 16;
    localparam int c_ACK_LAT = 64;
    localparam int c_SEQ_W   = 12;
    localparam int c_MOD     = 1 << c_SEQ_W;

    typedef struct {
        bit nak;
        int seq;
        int cyc;
    } dllp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 tlp_valid_i = 1'b0;
    logic [c_TL_W+47:0]   tlp_i = '0;
    logic                 lcrc_ok_i = 1'b0;
    logic                 tlp_ready_o;
    logic                 tl_valid_o;
    logic [c_TL_W-1:0]    tl_data_o;
    logic                 tl_ready_i = 1'b1;
    logic                 dllp_valid_o;
    logic                 dllp_nak_o;
    logic [c_SEQ_W-1:0]   dllp_seq_o;
    logic                 dllp_ready_i = 1'b1;
    logic [4:0]           credits_o;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            m_nrs = 0;
    int            m_pend_cyc = -1;
    int            m_last_acc_cyc = 0;
    logic [63:0]   exp_q[$];
    dllp_t         obs_q[$];
    logic [63:0]   last_payload;

    always #5 clk = ~clk;

    pcie_dll_rx_seq #(
        .TL_W       (c_TL_W),
        .FIFO_DEPTH (c_DEPTH),
        .ACK_LAT    (c_ACK_LAT),
        .SEQ_W      (c_SEQ_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tlp_valid_i  (tlp_valid_i),
        .tlp_i        (tlp_i),
        .lcrc_ok_i    (lcrc_ok_i),
        .tlp_ready_o  (tlp_ready_o),
        .tl_valid_o   (tl_valid_o),
        .tl_data_o    (tl_data_o),
        .tl_ready_i   (tl_ready_i),
        .dllp_valid_o (dllp_valid_o),
        .dllp_nak_o   (dllp_nak_o),
        .dllp_seq_o   (dllp_seq_o),
        .dllp_ready_i (dllp_ready_i),
        .credits_o    (credits_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the RX buffer is a queue of expected payloads, the
    // receiver state is just next_rcv_seq; effects of the coming edge are
    // applied after the current outputs are compared.
    always @(negedge clk) begin
        int s;
        int diff;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            obs_q.delete();
            m_nrs      = 0;
            m_pend_cyc = -1;
        end else begin
            check("credits", credits_o, c_DEPTH - exp_q.size());
            check("tlp_ready", tlp_ready_o, exp_q.size() < c_DEPTH);
            check("tl_valid", tl_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) check("tl_data", tl_data_o, exp_q[0]);
            if (dllp_valid_o && dllp_ready_i) begin
                obs_q.push_back('{nak: dllp_nak_o, seq: int'(dllp_seq_o), cyc: cyc});
                m_pend_cyc = -1;
            end
            if (tl_valid_o && tl_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
            if (tlp_valid_i && tlp_ready_o) begin
                s = int'(tlp_i[c_TL_W+32 +: c_SEQ_W]);
                diff = (m_nrs - s) & (c_MOD - 1);
                m_last_acc_cyc = cyc;
                if (lcrc_ok_i && s == m_nrs) begin
                    exp_q.push_back(tlp_i[32 +: c_TL_W]);
                    m_nrs = (m_nrs + 1) % c_MOD;
                    if (m_pend_cyc < 0) m_pend_cyc = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int seq, input bit ok);
        logic [11:0] s;
        s = seq[11:0];
        last_payload = {$urandom, $urandom};
        tlp_i        = {4'b0000, s, last_payload, 32'($urandom)};
        lcrc_ok_i    = ok;
        tlp_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        tlp_valid_i = 1'b0;
        lcrc_ok_i   = 1'b0;
    endtask

    task automatic do_reset();
        tlp_valid_i = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst tlp_ready", tlp_ready_o, 1);
        check("rst credits", credits_o, c_DEPTH);
        check("rst tl_valid", tl_valid_o, 0);
        check("rst tl_data", tl_data_o, 0);
        check("rst dllp_valid", dllp_valid_o, 0);
        check("rst dllp_nak", dllp_nak_o, 0);
        check("rst dllp_seq", dllp_seq_o, 0);
        tick(1);
    endtask

    task automatic expect_dllp(input string tag, input bit nak, input int seq,
                               input int ref_cyc, input int lo, input int hi);
        dllp_t o;
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " present"}, obs_q.size() != 0, 1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check({tag, " type"}, o.nak, nak);
            check({tag, " seq"}, o.seq, seq);
            if (hi >= 0) check({tag, " latency"}, (o.cyc - ref_cyc >= lo) && (o.cyc - ref_cyc <= hi), 1);
        end
        tick(1);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        repeat (n) @(negedge clk);
        check(tag, obs_q.size(), 0);
        tick(1);
    endtask

    task automatic wait_dllp_valid(input string tag);
        int n;
        n = 0;
        while (!dllp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, dllp_valid_o, 1);
    endtask

    initial begin
        int r1;
        int k;

        // 1: in-order delivery, 1-cycle latency, one coalesced Ack
        do_reset();
        send(0, 1);
        check("t1 latency valid", tl_valid_o, 1);
        check("t1 latency data", tl_data_o, last_payload);
        send(1, 1);
        send(2, 1);
        expect_dllp("t1 ack", 0, (m_nrs - 1) & (c_MOD - 1), m_pend_cyc, c_ACK_LAT, c_ACK_LAT + 2);
        expect_quiet("t1 single ack", c_ACK_LAT + 10);

        // 2: repeated bad LCRC gives one Nak; good TLP then acked
        do_reset();
        send(0, 0);
        r1 = m_last_acc_cyc;
        send(0, 0);
        expect_dllp("t2 nak", 1, 4095, r1, 1, 3);
        expect_quiet("t2 one nak", 10);
        send(0, 1);
        expect_dllp("t2 ack", 0, 0, m_pend_cyc, c_ACK_LAT, c_ACK_LAT + 2);

        // 3: duplicate discarded, immediate Ack
        do_reset();
        tl_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(i, 1);
        send(3, 1);
        r1 = m_last_acc_cyc;
        check("t3 credits", credits_o, c_DEPTH - 5);
        expect_dllp("t3 dup ack", 0, 4, r1, 1, 3);
        expect_quiet("t3 no extra ack", c_ACK_LAT + 10);
        tl_ready_i = 1'b1;
        tick(10);

        // 4: back-pressure fills the buffer
        do_reset();
        tl_ready_i = 1'b0;
        for (int i = 0; i < c_DEPTH + 2; i++) send(m_nrs, 1);
        check("t4 ready low", tlp_ready_o, 0);
        check("t4 credits zero", credits_o, 0);
        tl_ready_i = 1'b1;
        tick(1);
        tl_ready_i = 1'b0;
        @(negedge clk);
        check("t4 credits one", credits_o, 1);
        check("t4 ready back", tlp_ready_o, 1);
        tl_ready_i = 1'b1;
        tick(20);

        // 5: sequence wrap and Nak for a TLP ahead
        do_reset();
        for (int i = 0; i < 4095; i++) send(m_nrs, 1);
        tick(c_ACK_LAT + 20);
        obs_q.delete();
        send(4095, 1);
        send(0, 1);
        send(2, 1);
        r1 = m_last_acc_cyc;
        expect_dllp("t5 nak", 1, 0, r1, 1, 3);
        expect_quiet("t5 ack superseded", c_ACK_LAT + 10);

        // 6: held Ack, queued Nak, reset mid-hold
        do_reset();
        dllp_ready_i = 1'b0;
        send(0, 1);
        wait_dllp_valid("t6 ack valid");
        tick(1);
        send(5, 0);
        tick(5);
        check("t6 hold valid", dllp_valid_o, 1);
        check("t6 hold type", dllp_nak_o, 0);
        check("t6 hold seq", dllp_seq_o, 0);
        dllp_ready_i = 1'b1;
        tick(1);
        dllp_ready_i = 1'b0;
        expect_dllp("t6 ack", 0, 0, 0, 0, -1);
        wait_dllp_valid("t6 nak valid");
        check("t6 nak type", dllp_nak_o, 1);
        check("t6 nak seq", dllp_seq_o, 0);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async valid", dllp_valid_o, 0);
        check("t6 async nak", dllp_nak_o, 0);
        check("t6 async credits", credits_o, c_DEPTH);
        check("t6 async tl_valid", tl_valid_o, 0);
        dllp_ready_i = 1'b1;
        tick(2);

        // 7: randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tl_ready_i   = ($urandom_range(0, 3) != 0);
            dllp_ready_i = $urandom_range(0, 1);
            k = $urandom_range(0, 9);
            if (k < 6)       send(m_nrs, 1);
            else if (k == 6) send((m_nrs - $urandom_range(1, c_MOD / 2)) & (c_MOD - 1), 1);
            else if (k == 7) send($urandom_range(0, c_MOD - 1), 0);
            else if (k == 8) send((m_nrs + $urandom_range(1, c_MOD / 2 - 1)) & (c_MOD - 1), 1);
            else             tick(1);
        end
        tl_ready_i   = 1'b1;
        dllp_ready_i = 1'b1;
        tick(c_ACK_LAT + 20);
        check("t7 drained", credits_o, c_DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, required finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pcie_dll_rx_seq.md
Name: pcie_dll_rx_seq

Overview:
Parametrised receive-side Data Link Layer for PCIe.
- Checks the LCRC verdict and sequence number of each incoming DLL TLP.
- Buffers good, in-order TLPs in an internal FIFO and forwards them to the Transaction Layer over a valid/ready handshake.
- Generates Ack/Nak DLLPs per the NEXT_RCV_SEQ / NAK_SCHEDULED rules, with an Ack coalescing timer.
- Reports free receive-buffer credits.
- Sits between the PHY RX deframer and the TL RX.

Parameters:
- TL_W, 256, TL TLP width in bits. DLL word width = 16 + TL_W + 32.
- FIFO_DEPTH, 16, RX buffer entries. Power of 2, minimum 2.
- ACK_LAT, 64, cycles an Ack may be coalesced before it is forced out. Minimum 1.
- SEQ_W, 12, sequence number width. Fixed at 12 for PCIe; parametrised for test.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tlp_valid_i  in  1  PHY TLP valid
- tlp_i  in  TL_W+48  layout {4'b0, seq[11:0], TLP[TL_W-1:0], LCRC[31:0]}
- lcrc_ok_i  in  1  LCRC check result for tlp_i; qualified by tlp_valid_i
- tlp_ready_o  out  1  accept from PHY
- tl_valid_o  out  1  TLP to TL valid
- tl_data_o  out  TL_W  TLP to TL
- tl_ready_i  in  1  TL accept
- dllp_valid_o  out  1  Ack/Nak DLLP valid
- dllp_nak_o  out  1  0 = Ack, 1 = Nak
- dllp_seq_o  out  SEQ_W  AckNak_Seq_Num
- dllp_ready_i  in  1  DLLP TX accept
- credits_o  out  $clog2(FIFO_DEPTH)+1  free FIFO entries

Behaviour:
Reset:
- All outputs 0 except tlp_ready_o = 1 and credits_o = FIFO_DEPTH.
- next_rcv_seq = 0, nak_sched = 0, ack_pending = 0, ack_timer = 0, FSM in IDLE, FIFO empty.
- Reset mid-operation drops FIFO contents and any pending DLLP immediately.

Ingress:
- tlp_ready_o = !fifo_full. A TLP is accepted when tlp_valid_i && tlp_ready_o.
- Accepted TLPs are classified by priority:
  1. !lcrc_ok_i → discard. If !nak_sched, set nak_sched and request Nak.
  2. seq == next_rcv_seq → write TLP to FIFO, next_rcv_seq += 1 (mod 2^SEQ_W, 4095 wraps to 0), clear nak_sched, set ack_pending.
  3. (next_rcv_seq - seq) mod 2^SEQ_W in [1, 2^(SEQ_W-1)] → duplicate. Discard and request immediate Ack (ack_force).
  4. Otherwise (seq ahead) → treat as rule 1.
- Nak requests while nak_sched = 1 are suppressed.

FIFO:
- Registered, write-to-read latency 1 cycle (a TLP accepted in cycle N appears on tl_valid_o in cycle N+1).
- Simultaneous read and write when full is not possible because ready is low when full.
- Simultaneous read and write when not full leaves the count unchanged.
- tl_data_o holds stable while tl_valid_o && !tl_ready_i.

Ack timer:
- Counts every cycle while ack_pending; reset to 0 when an Ack is sent.
- An Ack request fires when ack_timer == ACK_LAT-1 or ack_force.

DLLP FSM:
- IDLE → SEND_NAK on a Nak request (Nak has priority over Ack).
- IDLE → SEND_ACK on an Ack request.
- SEND_x: dllp_valid_o = 1 and dllp_seq_o = next_rcv_seq - 1 (mod 2^SEQ_W), sampled on entry.
  - Outputs hold until dllp_ready_i; then return to IDLE.
  - Ack completion clears ack_pending and ack_force.
- A Nak request arriving during SEND_ACK is latched and sent next.
- An Ack is superseded by a pending Nak.
- With next_rcv_seq = 0, dllp_seq_o = 4095.

Credits:
- credits_o = FIFO_DEPTH - count, registered, updated 1 cycle after a push or pop.

Optional Feature:
Macro DLL_RX_STATS_EN.
- Defined: adds 16-bit saturating outputs stat_bad_crc_o, stat_dup_o, stat_nak_o.
  - stat_bad_crc_o and stat_dup_o increment on the respective ingress classification.
  - stat_nak_o increments on Nak DLLP handshake completion.
  - All reset to 0 and hold at 16'hFFFF when saturated.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then seq 0, 1, 2 sent with good LCRC, tl_ready_i = 1 → TLPs on tl_data_o in order, 1-cycle latency. Single Ack with seq 2 after ACK_LAT = 64 cycles; next_rcv_seq = 3.
2. seq 0 with lcrc_ok_i = 0, then seq 0 bad again → exactly one Nak with seq 4095. Then seq 0 good → accepted, nak_sched cleared, Ack seq 0.
3. After seq 0..4 accepted, resend seq 3 → discarded, FIFO unchanged, immediate Ack seq 4 without waiting for the timer.
4. tl_ready_i = 0 and FIFO_DEPTH + 2 TLPs offered → tlp_ready_o drops after 16 accepts, credits_o = 0. One pop → credits_o = 1 one cycle later.
5. Drive next_rcv_seq to 4095, send seq 4095 then 0 → both accepted, wrap to 1. Seq 2 → Nak with seq 0.
6. dllp_ready_i = 0 while an Ack is pending and a bad-LCRC TLP arrives → Ack held until accepted, Nak follows. Assert rst_n mid-hold → dllp_valid_o = 0 immediately.
